// File: rtl/kse_pkg.sv
// Shared definitions for the keypad scanner: FSM state encoding, width helpers
// and the binary-to-BCD conversion used on the FIFO head.
package kse_pkg;

  typedef enum logic [1:0] {
    ST_SCAN      = 2'd0,
    ST_DEB_PRESS = 2'd1,
    ST_HOLD      = 2'd2,
    ST_DEB_REL   = 2'd3
  } kse_state_e;

  function automatic int kse_code_w(input int keys);
    return (keys > 1) ? $clog2(keys) : 1;
  endfunction

  function automatic int kse_count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Key codes never exceed 63, so a divide/modulo by ten is exact.
  function automatic logic [7:0] kse_bin2bcd(input logic [7:0] bin);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(bin / 8'd10);
    units = 4'(bin % 8'd10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/kse_fifo.sv
// Show-ahead key FIFO; the head output falls back to the last popped word
// when the FIFO is empty.
module kse_fifo
  import kse_pkg::*;
#(
  parameter  int W     = 4,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int NW    = kse_count_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [NW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  last_q;
  logic          do_pop, do_push;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == NW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign count_o = cnt_q;
  assign data_o  = empty_o ? last_q : mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) begin
        rd_q   <= rd_q + 1'b1;
        last_q <= mem_q[rd_q];
      end
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/kse_scan_p.sv
// Debounced row/column keypad scanner feeding a key-code FIFO with BCD head view.
// One key event per press; no auto-repeat.
module kse_scan_p
  import kse_pkg::*;
#(
  parameter  int ROWS     = 4,
  parameter  int COLS     = 4,
  parameter  int DEPTH    = 8,
  parameter  int SCAN_DIV = 16,
  parameter  int DEB      = 4,
  localparam int CW       = kse_code_w(ROWS * COLS),
  localparam int NW       = kse_count_w(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [ROWS-1:0] row_i,
  input  logic            read_i,
  input  logic            clr_ovf_i,
  output logic [COLS-1:0] col_o,
  output logic [CW-1:0]   code_o,
  output logic [7:0]      bcd_o,
  output logic            valid_o,
  output logic [NW-1:0]   count_o,
  output logic            ovf_o
);

  localparam int CIW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RIW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEBW = (DEB > 1) ? $clog2(DEB) : 1;

  kse_state_e      state_q, state_d;
  logic [CIW-1:0]  col_idx_q, col_idx_d, col_next;
  logic [DIVW-1:0] div_q, div_d;
  logic [DEBW-1:0] deb_q, deb_d;
  logic [ROWS-1:0] pat_q, pat_d;
  logic            ovf_q, ovf_d;
  logic [RIW-1:0]  low_row;
  logic [CW-1:0]   key_code;
  logic            key_evt, fifo_full, fifo_empty, pop, drop;

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    assign col_o[gi] = (col_idx_q == CIW'(gi));
  end

  assign col_next = (col_idx_q == CIW'(COLS - 1)) ? '0 : col_idx_q + 1'b1;

  // Lowest closed row wins when several rows are closed together.
  always_comb begin
    low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (pat_q[i]) low_row = RIW'(i);
    end
  end

  assign key_code = CW'(int'(col_idx_q) * ROWS + int'(low_row));

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    div_d     = div_q;
    deb_d     = deb_q;
    pat_d     = pat_q;
    key_evt   = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (row_i != '0) begin
          state_d = ST_DEB_PRESS;
          pat_d   = row_i;
          deb_d   = '0;
          div_d   = '0;
        end else if (div_q == DIVW'(SCAN_DIV - 1)) begin
          div_d     = '0;
          col_idx_d = col_next;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_DEB_PRESS: begin
        // The latched pattern is non-zero, so a zero row also counts as a change.
        if (row_i != pat_q) begin
          state_d = ST_SCAN;
        end else if (deb_q == DEBW'(DEB - 1)) begin
          key_evt = 1'b1;
          state_d = ST_HOLD;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (row_i == '0) begin
          state_d = ST_DEB_REL;
          deb_d   = '0;
        end
      end
      ST_DEB_REL: begin
        if (row_i != '0) begin
          state_d = ST_HOLD;
        end else if (deb_q == DEBW'(DEB - 1)) begin
          state_d   = ST_SCAN;
          col_idx_d = col_next;
          div_d     = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  assign pop   = read_i & ~fifo_empty;
  assign drop  = key_evt & fifo_full & ~pop;
  assign ovf_d = drop ? 1'b1 : (clr_ovf_i ? 1'b0 : ovf_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_SCAN;
      col_idx_q <= '0;
      div_q     <= '0;
      deb_q     <= '0;
      pat_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      div_q     <= div_d;
      deb_q     <= deb_d;
      pat_q     <= pat_d;
      ovf_q     <= ovf_d;
    end
  end

  kse_fifo #(
    .W    (CW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (key_evt),
    .pop_i  (read_i),
    .data_i (key_code),
    .data_o (code_o),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(count_o)
  );

  assign valid_o = ~fifo_empty;
  assign bcd_o   = kse_bin2bcd(8'(code_o));
  assign ovf_o   = ovf_q;

endmodule

// File: doc/kse_scan_p.md
KSE_SCAN_P -- requirements
Module: kse_scan_p

Interface
REQ-001 Parameter ROWS, default 4: number of row inputs, legal 1..8.
REQ-002 Parameter COLS, default 4: number of column drives, legal 1..8.
REQ-003 Parameter DEPTH, default 8: key FIFO entries, power of two, 2..64.
REQ-004 Parameter SCAN_DIV, default 16: clock cycles each column is driven while scanning, at least 1.
REQ-005 Parameter DEB, default 4: consecutive equal row samples required for press or release, at least 1.
REQ-006 clock  in  1  single system clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 row  in  ROWS  row sense lines; bit high means a key is closed in the driven column.
REQ-009 read  in  1  consumer pop request, sampled each clock.
REQ-010 clr_ovf  in  1  single-cycle pulse that clears ovf.
REQ-011 col  out  COLS  one-hot active-high column drive.
REQ-012 code  out  CW  binary key index at FIFO head; CW = clog2(ROWS*COLS), minimum 1.
REQ-013 BCD  out  8  two-digit packed BCD of code; tens in [7:4], units in [3:0].
REQ-014 valid  out  1  high while the FIFO is non-empty.
REQ-015 count  out  clog2(DEPTH)+1  current FIFO occupancy.
REQ-016 ovf  out  1  sticky flag; a debounced key was dropped because the FIFO was full.

Function
REQ-017 The scanner FSM has four states: SCAN, DEB_PRESS, HOLD, DEB_REL.
- SCAN: col advances one position (COLS-1 wraps to 0) every SCAN_DIV cycles.
- SCAN to DEB_PRESS: row is non-zero; col freezes and the row pattern is latched.
REQ-018 DEB_PRESS:
- row differs from the latched pattern, or goes zero: return to SCAN with col unchanged.
- DEB consecutive equal samples: emit one key event, enter HOLD.
REQ-019 Key index = col_idx*ROWS + lowest set row bit; multiple closed rows report only the lowest.
REQ-020 HOLD stays while row is non-zero and emits no further events (no auto-repeat).
- row zero: enter DEB_REL.
REQ-021 DEB_REL:
- row non-zero: return to HOLD.
- DEB consecutive zero samples: enter SCAN, col advanced by one.
REQ-022 Key event push: the FIFO accepts it when not full, or when a pop occurs in the same cycle.
- Otherwise the event is discarded and ovf is set on the next edge.
REQ-023 Pop: read high while valid high removes the head on that edge; read while empty is ignored, no underflow.
REQ-024 Simultaneous push and pop: count unchanged and FIFO order preserved; when empty, a pop is impossible and the push proceeds.
REQ-025 FIFO is show-ahead: code and BCD reflect the head combinationally from registered storage. Latency press-to-valid = DEB+1 cycles after row first seen non-zero in SCAN.
REQ-026 Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-027 When empty, code and BCD hold the last popped value (0 after reset).
REQ-028 BCD conversion covers 0..63 exactly; no saturation is needed.
REQ-029 clr_ovf clears ovf. A drop in the same cycle as clr_ovf leaves ovf set (set wins).

Reset
REQ-030 reset low asynchronously forces the following; all counters are also cleared:
- FSM to SCAN
- col = 1 (column 0 driven)
- FIFO empty: count 0, valid 0
- code 0, BCD 8'h00, ovf 0
REQ-031 Reset mid-debounce or mid-hold discards any pending event; stored FIFO contents are lost.
REQ-032 On reset release, scanning begins at column 0 on the first clock edge.

Structure
REQ-033 Package kse_pkg holds:
- the scanner state enum
- the clog2-derived width constants
- the bin-to-BCD conversion function
REQ-034 One sub-module, kse_fifo, is parameterised by width and DEPTH and provides the push/pop/full/empty/count logic. The scanner FSM and encoder live in kse_scan_p.

Verification
REQ-035 Defaults; press row[2] in column 1 and hold 40 cycles -> exactly one entry, code 6, BCD 8'h06, valid high; read pulse -> valid low.
REQ-036 DEB=4; bounce row[0] for 3 cycles then release -> no entry, FSM back in SCAN, count 0.
REQ-037 DEPTH=8; nine distinct press/release cycles, no reads -> count 8, ovf 1, FIFO holds the first eight codes in order; clr_ovf -> ovf 0.
REQ-038 FIFO full with read asserted in the cycle a new key is pushed -> count stays 8, ovf stays 0, oldest entry removed.
REQ-039 ROWS=8, COLS=8; press row[7] in column 7 -> code 63, BCD 8'h63.
REQ-040 Assert reset low during HOLD with three entries queued -> count 0, valid 0, col 1 immediately, no event after release.
